arm_alu: RTL and testbench
==========================

// Module: arm_alu
// PURPOSE
//  32-bit ARM-subset ALU for the single-cycle core datapath, between the SrcB mux and the result mux.
//  Combinational ADD/SUB/AND/ORR result plus NZCV flags feed ALUResult, the data address and the PC mux in the same cycle.
//  Holds a clocked NZCV status register, written per flag group, for downstream condition checking.
// PARAMETERS
//  WIDTH  32  datapath width; flag rules below assume MSB = bit WIDTH-1
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-low reset (0 = reset, sampled on rising clk edge)
//  SrcA        in   WIDTH  operand A (Rn)
//  SrcB        in   WIDTH  operand B (Rm or extended immediate)
//  ALUControl  in   2      00 ADD, 01 SUB, 10 AND, 11 ORR
//  FlagW       in   2      [1] write N,Z to status reg; [0] write C,V to status reg
//  ShType      in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR (used only with ARM_ALU_SHIFT_EN)
//  ShAmt       in   5      shift amount 0..31 (used only with ARM_ALU_SHIFT_EN)
//  ALUResult   out  WIDTH  combinational result
//  ALUFlags    out  4      combinational {N,Z,C,V} of current operation
//  Flags       out  4      registered {N,Z,C,V} status
// BEHAVIOUR
//  - Combinational path has zero latency; ALUResult/ALUFlags settle from inputs alone, no handshake.
//  - ADD: sum = A + B; SUB: sum = A + ~B + 1; AND: A & B; ORR: A | B. Results wrap modulo 2^WIDTH.
//  - N = ALUResult[WIDTH-1]; Z = (ALUResult == 0).
//  - ADD/SUB: C = carry-out of the WIDTH-bit add (SUB: C=1 means no borrow, A >= B unsigned).
//  - ADD/SUB: V = ~(ALUControl[0]^A[MSB]^B[MSB]) & (sum[MSB]^A[MSB]).
//  - AND/ORR: C = 0, V = 0 (except shifter carry, see CONFIGURATION).
//  - Flags register: on rising clk, reset==0 -> Flags = 4'b0000 (overrides FlagW).
//  - Otherwise FlagW[1] loads Flags[3:2] <= ALUFlags[3:2] and FlagW[0] loads Flags[1:0] <= ALUFlags[1:0].
//  - The two groups are independent; FlagW = 00 holds both.
//  - A reset asserted mid-operation affects only Flags; combinational outputs keep tracking inputs during reset.
//  - Undefined/X ALUControl is impossible (2-bit fully decoded); no default-X outputs.
// CONFIGURATION
//  ARM_ALU_SHIFT_EN defined: SrcB passes through a barrel shifter before the ALU, selected by ShType/ShAmt.
//   - ShAmt=0 means no shift; there is no RRX.
//   - LSR/ASR/ROR use standard ARM semantics.
//   - For AND/ORR, C = last bit shifted out when ShAmt != 0, else 0.
//  ARM_ALU_SHIFT_EN undefined: ShType/ShAmt are ignored (ports remain, unconnected internally); SrcB is used as-is.
// STRUCTURE
//  Package arm_alu_pkg:
//   - ALU op localparams ALU_ADD/SUB/AND/ORR (2'b00..2'b11)
//   - shift type localparams SH_LSL/LSR/ASR/ROR
//   - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//  Sub-module arm_alu_shifter (combinational; WIDTH operand, ShType, ShAmt -> shifted value, carry-out),
//   instantiated only under ARM_ALU_SHIFT_EN.
//  Top contains the adder, logic ops, flag generation and the 4-bit flags register.
// TESTING
//  1. ADD 7 + 5 -> ALUResult=12, ALUFlags=4'b0000.
//  2. SUB 5 - 5 -> ALUResult=0, ALUFlags=4'b0110 (Z,C). SUB 3 - 5 -> 0xFFFFFFFE, ALUFlags=4'b1000.
//  3. ADD 0x7FFFFFFF + 1 -> 0x80000000, ALUFlags=4'b1001.
//     ADD 0xFFFFFFFF + 1 -> 0, ALUFlags=4'b0110.
//  4. AND 0x0000F0F0 & 0x00000FF0 -> 0x000000F0.
//     ORR 0x0000F000 | 0x0000000F -> 0x0000F00F; C=V=0 both.
//  5. Flags reg: after SUB 5-5 with FlagW=01 -> Flags=4'b0010; then ADD 0x7FFFFFFF+1 with FlagW=10 -> Flags=4'b1010.
//     reset=0 for one edge -> Flags=0.
//  6. ARM_ALU_SHIFT_EN, ADD A=0, B=1, LSL 4 -> 0x10.
//     ORR A=0, B=0x80000001, LSR 1 -> 0x40000000, C=1.
//     ASR 4 of 0x80000000 -> 0xF8000000.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// arm_alu_pkg: ALU opcodes, shift types and NZCV flag bit positions.
package arm_alu_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/arm_alu_shifter.sv
// arm_alu_shifter: combinational ARM barrel shifter (LSL/LSR/ASR/ROR, amount 0 = pass-through) with carry-out.
module arm_alu_shifter
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [1:0]       type_i,
    input  logic [4:0]       amt_i,
    output logic [WIDTH-1:0] y_o,
    output logic             c_o
);
    logic [WIDTH:0] lsl, lsr, asr;
    logic [WIDTH-1:0] ror;
    // Extra bit on each side catches the last bit shifted out
    assign lsl = {1'b0, a_i} << amt_i;
    assign lsr = {a_i, 1'b0} >> amt_i;
    assign asr = $signed({a_i, 1'b0}) >>> amt_i;
    assign ror = (a_i >> amt_i) | (a_i << (WIDTH - int'(amt_i)));
    always_comb begin
        y_o = type_i == SH_LSL ? lsl[WIDTH-1:0] :
              type_i == SH_LSR ? lsr[WIDTH:1] :
              type_i == SH_ASR ? asr[WIDTH:1] : ror;
        c_o = amt_i == '0 ? 1'b0 :
              type_i == SH_LSL ? lsl[WIDTH] :
              type_i == SH_LSR ? lsr[0] :
              type_i == SH_ASR ? asr[0] : ror[WIDTH-1];
    end
endmodule

// File: rtl/arm_alu.sv
// arm_alu: ADD/SUB/AND/ORR ALU with NZCV flags and a per-group status register; ARM_ALU_SHIFT_EN adds a SrcB barrel shifter.
module arm_alu
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    input  logic [1:0]       FlagW,
    input  logic [1:0]       ShType,
    input  logic [4:0]       ShAmt,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       Flags
);
    logic [WIDTH-1:0] b, bx;
    logic [WIDTH:0] sum;
    logic sh_c, arith, sub;
    logic [3:0] flags_q, flags_d;
`ifdef ARM_ALU_SHIFT_EN
    arm_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a_i(SrcB),
        .type_i(ShType),
        .amt_i(ShAmt),
        .y_o(b),
        .c_o(sh_c)
    );
`else
    logic unused_sh;
    assign unused_sh = ^{ShType, ShAmt};
    assign b = SrcB;
    assign sh_c = 1'b0;
`endif
    assign sub = ALUControl == ALU_SUB;
    assign arith = sub | (ALUControl == ALU_ADD);
    assign bx = sub ? ~b : b;
    assign sum = {1'b0, SrcA} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign ALUResult = arith ? sum[WIDTH-1:0] :
                       ALUControl == ALU_AND ? SrcA & b : SrcA | b;
    assign ALUFlags = {ALUResult[WIDTH-1], ~|ALUResult, arith ? sum[WIDTH] : sh_c,
                       arith & ~(sub ^ SrcA[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ SrcA[WIDTH-1])};
    assign flags_d = {FlagW[1] ? ALUFlags[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z],
                      FlagW[0] ? ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V]};
    always_ff @(posedge clk) flags_q <= !reset ? 4'b0000 : flags_d;
    assign Flags = flags_q;
endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: random + directed checks of arm_alu against an arithmetic reference model (honours ARM_ALU_SHIFT_EN).
module tb_arm_alu;
    import arm_alu_pkg::*;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] SrcA = '0, SrcB = '0, ALUResult;
    logic [1:0] ALUControl = '0, FlagW = '0, ShType = '0;
    logic [4:0] ShAmt = '0;
    logic [3:0] ALUFlags, Flags, exp_flags = '0;
    logic [35:0] m_pos, m_neg;
    int passed = 0, total = 0;
    bit chk = 0;

    arm_alu dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .FlagW(FlagW), .ShType(ShType), .ShAmt(ShAmt),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags), .Flags(Flags)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] model(input logic [31:0] a, bi, input logic [1:0] op, st, input logic [4:0] sa);
        logic [31:0] b = bi, r;
        logic sc = 1'b0, c = 1'b0, v = 1'b0;
        longint s, ss;
`ifdef ARM_ALU_SHIFT_EN
        if (sa != 0) begin
            case (st)
                SH_LSL: begin s = longint'(bi) << sa; b = s[31:0]; sc = s[32]; end
                SH_LSR: begin b = bi >> sa; sc = bi[sa-1]; end
                SH_ASR: begin b = $signed(bi) >>> sa; sc = bi[sa-1]; end
                default: begin b = (bi >> sa) | (bi << (32 - sa)); sc = b[31]; end
            endcase
        end
`endif
        case (op)
            ALU_ADD: begin
                s = longint'(a) + longint'(b); r = s[31:0]; c = s[32];
                ss = longint'($signed(a)) + longint'($signed(b));
                v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
            end
            ALU_SUB: begin
                s = longint'(a) - longint'(b); r = s[31:0]; c = a >= b;
                ss = longint'($signed(a)) - longint'($signed(b));
                v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
            end
            ALU_AND: begin r = a & b; c = sc; end
            default: begin r = a | b; c = sc; end
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    always @(posedge clk) begin
        m_pos = model(SrcA, SrcB, ALUControl, ShType, ShAmt);
        exp_flags = !reset ? 4'b0000 : {FlagW[1] ? m_pos[35:34] : exp_flags[3:2],
                                        FlagW[0] ? m_pos[33:32] : exp_flags[1:0]};
    end

    always @(negedge clk) if (chk) begin
        m_neg = model(SrcA, SrcB, ALUControl, ShType, ShAmt);
        check("result", {4'b0, ALUResult}, {4'b0, m_neg[31:0]});
        check("aluflags", {32'b0, ALUFlags}, {32'b0, m_neg[35:32]});
        check("flags_reg", {32'b0, Flags}, {32'b0, exp_flags});
    end

    task automatic step(input logic [31:0] a, b, input logic [1:0] op, fw, st = 2'b00, input logic [4:0] sa = 5'd0);
        @(posedge clk); #1;
        SrcA = a; SrcB = b; ALUControl = op; FlagW = fw; ShType = st; ShAmt = sa;
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk = 1;
        @(negedge clk); #1;
        check("reset_flags", {32'b0, Flags}, 36'h0);
        step(32'd7, 32'd5, ALU_ADD, 2'b00);
        check("add_7_5", {ALUFlags, ALUResult}, {4'b0000, 32'd12});
        step(32'd5, 32'd5, ALU_SUB, 2'b01);
        check("sub_5_5", {ALUFlags, ALUResult}, {4'b0110, 32'd0});
        step(32'h7FFFFFFF, 32'd1, ALU_ADD, 2'b10);
        check("add_ovf", {ALUFlags, ALUResult}, {4'b1001, 32'h80000000});
        check("flags_cv_only", {32'b0, Flags}, {32'b0, 4'b0010});
        step(32'd3, 32'd5, ALU_SUB, 2'b00);
        check("sub_3_5", {ALUFlags, ALUResult}, {4'b1000, 32'hFFFFFFFE});
        check("flags_nz_only", {32'b0, Flags}, {32'b0, 4'b1010});
        step(32'hFFFFFFFF, 32'd1, ALU_ADD, 2'b00);
        check("add_wrap", {ALUFlags, ALUResult}, {4'b0110, 32'd0});
        check("flags_hold", {32'b0, Flags}, {32'b0, 4'b1010});
        step(32'h0000F0F0, 32'h00000FF0, ALU_AND, 2'b00);
        check("and", {ALUFlags, ALUResult}, {4'b0000, 32'h000000F0});
        step(32'h0000F000, 32'h0000000F, ALU_ORR, 2'b11);
        check("orr", {ALUFlags, ALUResult}, {4'b0000, 32'h0000F00F});
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        check("flags_in_reset", {32'b0, Flags}, 36'h0);
        check("comb_in_reset", {ALUFlags, ALUResult}, {4'b0000, 32'h0000F00F});
        @(posedge clk); #1 reset = 1'b1;
`ifdef ARM_ALU_SHIFT_EN
        step(32'd0, 32'd1, ALU_ADD, 2'b00, SH_LSL, 5'd4);
        check("lsl4", {ALUFlags, ALUResult}, {4'b0000, 32'h10});
        step(32'd0, 32'h80000001, ALU_ORR, 2'b00, SH_LSR, 5'd1);
        check("lsr1_carry", {ALUFlags, ALUResult}, {4'b0010, 32'h40000000});
        step(32'd0, 32'h80000000, ALU_ADD, 2'b00, SH_ASR, 5'd4);
        check("asr4", {ALUFlags, ALUResult}, {4'b1000, 32'hF8000000});
`endif
        for (int i = 0; i < 500; i++) begin
            step(pick(), pick(), 2'($urandom), 2'($urandom), 2'($urandom), 5'($urandom));
            reset = $urandom_range(0, 19) != 0;
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
